// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer.
// Holds the opcode encodings, ROB tag width, memory size codes, the FSM
// state encoding, the default IO region base and small opcode helpers.
package load_store_buffer_pkg;

  localparam int          LSB_OP_W    = 6;
  localparam int          LSB_TAG_W   = 4;
  localparam logic [31:0] LSB_IO_BASE = 32'h30000;

  localparam logic [LSB_OP_W-1:0] OP_LB  = 6'd0;
  localparam logic [LSB_OP_W-1:0] OP_LH  = 6'd1;
  localparam logic [LSB_OP_W-1:0] OP_LW  = 6'd2;
  localparam logic [LSB_OP_W-1:0] OP_LBU = 6'd3;
  localparam logic [LSB_OP_W-1:0] OP_LHU = 6'd4;
  localparam logic [LSB_OP_W-1:0] OP_SB  = 6'd5;
  localparam logic [LSB_OP_W-1:0] OP_SH  = 6'd6;
  localparam logic [LSB_OP_W-1:0] OP_SW  = 6'd7;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_WAIT  = 2'd1,
    ST_STORE_WAIT = 2'd2,
    ST_FLUSH_WAIT = 2'd3
  } lsb_state_t;

  function automatic logic op_is_store(input logic [LSB_OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [LSB_OP_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_WORD;
    endcase
  endfunction

  // Store data is presented right-aligned with unused upper bytes cleared.
  function automatic logic [31:0] store_align(input logic [LSB_OP_W-1:0] op,
                                              input logic [31:0] data);
    case (op)
      OP_SB:   return {24'h0, data[7:0]};
      OP_SH:   return {16'h0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_buffer_load_extend.sv
// lsb_load_extend: combinational load-result extension.
// Ports: op    - load opcode
//        rdata - right-aligned data from the memory controller
//        ext   - 32-bit sign- or zero-extended result for the CDB
module lsb_load_extend
  import load_store_buffer_pkg::*;
(
  input  logic [LSB_OP_W-1:0] op,
  input  logic [31:0]         rdata,
  output logic [31:0]         ext
);

  always_comb begin
    ext = rdata;
    case (op)
      OP_LB:   ext = {{24{rdata[7]}}, rdata[7:0]};
      OP_LH:   ext = {{16{rdata[15]}}, rdata[15:0]};
      OP_LBU:  ext = {24'h0, rdata[7:0]};
      OP_LHU:  ext = {16'h0, rdata[15:0]};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order memory execution stage behind the load/store
// reservation station. Entries are queued in program order, the address is
// formed at enqueue (reg1 + imm), and one memory transaction is in flight at
// a time: loads issue speculatively at head, stores only once committed.
// Ports: clk/rst (sync, active-high), rdy global enable, clear flush,
//        in_* enqueue from the RS (is_full back-pressure), commit_* from ROB,
//        store_ready_* to ROB, mem_req_*/mem_done/mem_rdata to the memory
//        controller, cdb_* load result broadcast.
// Optional macro LSB_IO_SAFE_EN: loads with addr >= IO_BASE wait at head
// until the ROB commits them instead of issuing speculatively.
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter int          TAG_W   = LSB_TAG_W,
  parameter int          OP_W    = LSB_OP_W,
  parameter logic [31:0] IO_BASE = LSB_IO_BASE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  output logic             is_full,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [31:0]      in_reg1,
  input  logic [31:0]      in_reg2,
  input  logic [31:0]      in_imm,
  input  logic [TAG_W-1:0] in_rob_tag,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  output logic             store_ready_valid,
  output logic [TAG_W-1:0] store_ready_tag,
  output logic             mem_req_valid,
  output logic             mem_req_we,
  output logic [1:0]       mem_req_size,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_req_wdata,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data
);

  localparam int             PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ALMOST = (PTR_W+1)'(DEPTH - 1);

  logic [DEPTH-1:0] valid_reg, committed_reg;
  logic [OP_W-1:0]  op_mem   [DEPTH];
  logic [31:0]      addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [PTR_W:0]   count_reg;
  lsb_state_t       state_reg, state_next;

  logic issue, pop, cdb_fire, enq_ok, io_hold;
  logic [31:0] ext_data;

  logic             head_valid, head_committed, head_is_store;
  logic [OP_W-1:0]  head_op;
  logic [31:0]      head_addr, head_data;
  logic [TAG_W-1:0] head_tag;

  assign head_valid     = valid_reg[head_reg];
  assign head_committed = committed_reg[head_reg];
  assign head_op        = op_mem[head_reg];
  assign head_addr      = addr_mem[head_reg];
  assign head_data      = data_mem[head_reg];
  assign head_tag       = tag_mem[head_reg];
  assign head_is_store  = op_is_store(head_op);

  // A full queue drops the entry; flush cycles accept nothing since any new
  // entry would be speculative and immediately discarded.
  assign enq_ok  = in_valid && !clear && (count_reg != CNT_FULL);
  assign is_full = (count_reg >= CNT_ALMOST);

`ifdef LSB_IO_SAFE_EN
  assign io_hold = !head_is_store && (head_addr >= IO_BASE) && !head_committed;
`else
  logic unused_io_base;
  assign io_hold        = 1'b0;
  assign unused_io_base = ^IO_BASE;
`endif

  // Committed stores form a contiguous run starting at head; that run is
  // exactly what survives a flush.
  logic [DEPTH-1:0] keep_mask;
  logic [PTR_W:0]   keep_cnt;
  always_comb begin : keep_scan
    logic             run;
    logic [PTR_W-1:0] idx;
    keep_mask = '0;
    keep_cnt  = '0;
    run       = 1'b1;
    idx       = head_reg;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_reg + PTR_W'(i);
      if (run && valid_reg[idx] && committed_reg[idx] && op_is_store(op_mem[idx])) begin
        keep_mask[idx] = 1'b1;
        keep_cnt       = keep_cnt + (PTR_W+1)'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  logic [DEPTH-1:0] enq_hit, pop_hit, commit_hit, drop_hit;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign enq_hit[gi]    = enq_ok && (tail_reg == PTR_W'(gi));
    assign pop_hit[gi]    = pop && (head_reg == PTR_W'(gi));
    assign commit_hit[gi] = commit_valid && valid_reg[gi] && (tag_mem[gi] == commit_tag);
    assign drop_hit[gi]   = clear && !keep_mask[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= '0;
      committed_reg <= '0;
    end else if (rdy) begin
      valid_reg     <= (valid_reg & ~pop_hit & ~drop_hit) | enq_hit;
      committed_reg <= (committed_reg | commit_hit) & ~enq_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && enq_ok) begin
      op_mem[tail_reg]   <= in_op;
      addr_mem[tail_reg] <= in_reg1 + in_imm;
      data_mem[tail_reg] <= in_reg2;
      tag_mem[tail_reg]  <= in_rob_tag;
    end
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    pop        = 1'b0;
    cdb_fire   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!clear && head_valid && !io_hold) begin
          if (!head_is_store) begin
            issue      = 1'b1;
            state_next = ST_LOAD_WAIT;
          end else if (head_committed) begin
            issue      = 1'b1;
            state_next = ST_STORE_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (mem_done) begin
          state_next = ST_IDLE;
          // A flush in the completion cycle discards the load silently.
          if (!clear) begin
            pop      = 1'b1;
            cdb_fire = 1'b1;
          end
        end else if (clear) begin
          state_next = ST_FLUSH_WAIT;
        end
      end
      ST_STORE_WAIT: begin
        if (mem_done) begin
          pop        = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_FLUSH_WAIT: begin
        if (mem_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      state_reg <= ST_IDLE;
    end else if (rdy) begin
      state_reg <= state_next;
      if (clear) begin
        // Only a store in STORE_WAIT can pop here, and it is inside keep_cnt.
        head_reg  <= head_reg + PTR_W'(pop);
        tail_reg  <= head_reg + keep_cnt[PTR_W-1:0];
        count_reg <= keep_cnt - (PTR_W+1)'(pop);
      end else begin
        tail_reg  <= tail_reg + PTR_W'(enq_ok);
        head_reg  <= head_reg + PTR_W'(pop);
        count_reg <= count_reg + (PTR_W+1)'(enq_ok) - (PTR_W+1)'(pop);
      end
    end
  end

  lsb_load_extend u_extend (
    .op    (head_op),
    .rdata (mem_rdata),
    .ext   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_valid     <= 1'b0;
      mem_req_we        <= 1'b0;
      mem_req_size      <= 2'd0;
      mem_req_addr      <= '0;
      mem_req_wdata     <= '0;
      cdb_valid         <= 1'b0;
      cdb_tag           <= '0;
      cdb_data          <= '0;
      store_ready_valid <= 1'b0;
      store_ready_tag   <= '0;
    end else if (rdy) begin
      // Request fields stay put after the pulse until the next issue.
      mem_req_valid <= issue;
      if (issue) begin
        mem_req_we    <= head_is_store;
        mem_req_size  <= op_size(head_op);
        mem_req_addr  <= head_addr;
        mem_req_wdata <= head_is_store ? store_align(head_op, head_data) : 32'h0;
      end
      cdb_valid <= cdb_fire;
      if (cdb_fire) begin
        cdb_tag  <= head_tag;
        cdb_data <= ext_data;
      end
      store_ready_valid <= enq_ok && op_is_store(in_op);
      if (enq_ok && op_is_store(in_op)) store_ready_tag <= in_rob_tag;
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
`timescale 1ns/1ps
module tb_load_store_buffer;
  import load_store_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, rdy, clear, is_full;
  logic             in_valid;
  logic [5:0]       in_op;
  logic [31:0]      in_reg1, in_reg2, in_imm;
  logic [TAG_W-1:0] in_rob_tag;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic             store_ready_valid;
  logic [TAG_W-1:0] store_ready_tag;
  logic             mem_req_valid, mem_req_we;
  logic [1:0]       mem_req_size;
  logic [31:0]      mem_req_addr, mem_req_wdata;
  logic             mem_done;
  logic [31:0]      mem_rdata;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;

  always #5 clk = ~clk;

  load_store_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .is_full(is_full),
    .in_valid(in_valid), .in_op(in_op), .in_reg1(in_reg1), .in_reg2(in_reg2),
    .in_imm(in_imm), .in_rob_tag(in_rob_tag),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .store_ready_valid(store_ready_valid), .store_ready_tag(store_ready_tag),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
    .mem_req_size(mem_req_size), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } cdb_t;

  req_t             exp_req_q[$];
  cdb_t             exp_cdb_q[$];
  logic [TAG_W-1:0] exp_sr_q[$];
  logic [31:0]      rdata_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int req_seen    = 0;
  int mem_lat     = 1;
  bit resp_busy   = 1'b0;
  bit mon_en      = 1'b0;

  // Output monitor: every request, CDB broadcast and store-ready pulse is
  // popped against the scoreboard in order.
  initial begin : monitor
    bit               prev_req;
    req_t             r;
    cdb_t             c;
    logic [TAG_W-1:0] t;
    prev_req = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        if (mem_req_valid) begin
          req_seen++;
          vectors++;
          if (prev_req) begin
            miscompares++;
            $display("FAIL req_pulse_width: mem_req_valid high two cycles, required one");
          end
          vectors++;
          if (exp_req_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_req: addr=%h we=%b, required no request", mem_req_addr, mem_req_we);
          end else begin
            r = exp_req_q.pop_front();
            if (mem_req_we !== r.we || mem_req_size !== r.size || mem_req_addr !== r.addr ||
                (r.we && mem_req_wdata !== r.wdata)) begin
              miscompares++;
              $display("FAIL req_fields: we=%b size=%0d addr=%h wdata=%h, required we=%b size=%0d addr=%h wdata=%h",
                       mem_req_we, mem_req_size, mem_req_addr, mem_req_wdata, r.we, r.size, r.addr, r.wdata);
            end else begin
              $display("req    we=%b size=%0d addr=%h wdata=%h ok", r.we, r.size, r.addr, mem_req_wdata);
            end
          end
        end
        if (cdb_valid) begin
          vectors++;
          if (exp_cdb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_cdb: tag=%0d data=%h, required no broadcast", cdb_tag, cdb_data);
          end else begin
            c = exp_cdb_q.pop_front();
            if (cdb_tag !== c.tag || cdb_data !== c.data) begin
              miscompares++;
              $display("FAIL cdb: tag=%0d data=%h, required tag=%0d data=%h", cdb_tag, cdb_data, c.tag, c.data);
            end else begin
              $display("cdb    tag=%0d data=%h ok", c.tag, c.data);
            end
          end
        end
        if (store_ready_valid) begin
          vectors++;
          if (exp_sr_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_store_ready: tag=%0d, required none", store_ready_tag);
          end else begin
            t = exp_sr_q.pop_front();
            if (store_ready_tag !== t) begin
              miscompares++;
              $display("FAIL store_ready_tag: got %0d, required %0d", store_ready_tag, t);
            end else begin
              $display("sready tag=%0d ok", t);
            end
          end
        end
      end
      prev_req = mem_req_valid;
    end
  end

  // Memory controller model: answers each request after mem_lat cycles and
  // checks that the request fields were held until completion.
  initial begin : responder
    req_t held;
    mem_done  = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_req_valid && !rst) begin
        resp_busy  = 1'b1;
        held.we    = mem_req_we;
        held.size  = mem_req_size;
        held.addr  = mem_req_addr;
        held.wdata = mem_req_wdata;
        repeat (mem_lat) @(posedge clk);
        #1;
        vectors++;
        if (mem_req_addr !== held.addr || mem_req_size !== held.size || mem_req_wdata !== held.wdata) begin
          miscompares++;
          $display("FAIL req_hold: addr=%h size=%0d at done, required addr=%h size=%0d",
                   mem_req_addr, mem_req_size, held.addr, held.size);
        end
        mem_done = 1'b1;
        if (!held.we && rdata_q.size() > 0) mem_rdata = rdata_q.pop_front();
        @(posedge clk); #1;
        mem_done  = 1'b0;
        mem_rdata = 32'h0;
        resp_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic enq(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] imm,
                     input logic [31:0] r2, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_op = op; in_reg1 = r1; in_imm = imm; in_reg2 = r2; in_rob_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic commit(input logic [TAG_W-1:0] tag);
    commit_valid = 1'b1; commit_tag = tag;
    @(posedge clk); #1;
    commit_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_req_q.size() != 0 || exp_cdb_q.size() != 0 || exp_sr_q.size() != 0 || resp_busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL %s_timeout: pending req=%0d cdb=%0d sready=%0d, required 0",
               name, exp_req_q.size(), exp_cdb_q.size(), exp_sr_q.size());
    end
  endtask

  task automatic wait_req(input int base, input string name);
    int n = 0;
    while (req_seen == base && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (req_seen == base) begin
      miscompares++;
      $display("FAIL %s_no_req: requests seen %0d, required more than %0d", name, req_seen, base);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0; in_op = '0;
    in_reg1 = '0; in_reg2 = '0; in_imm = '0; in_rob_tag = '0;
    commit_valid = 1'b0; commit_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({is_full, store_ready_valid, mem_req_valid, mem_req_we, cdb_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 00000",
               {is_full, store_ready_valid, mem_req_valid, mem_req_we, cdb_valid});
    end
    vectors++;
    if ({mem_req_addr, mem_req_wdata, cdb_data} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h cdb=%h, required 0", mem_req_addr, mem_req_wdata, cdb_data);
    end
    vectors++;
    if ({mem_req_size, cdb_tag, store_ready_tag} !== 10'h0) begin
      miscompares++;
      $display("FAIL reset_tags: size=%0d cdb_tag=%0d sr_tag=%0d, required 0", mem_req_size, cdb_tag, store_ready_tag);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  task automatic test_load_word();
    exp_req_q.push_back('{we: 1'b0, size: SIZE_WORD, addr: 32'h104, wdata: 32'h0});
    rdata_q.push_back(32'hDEADBEEF);
    exp_cdb_q.push_back('{tag: 4'd5, data: 32'hDEADBEEF});
    enq(OP_LW, 32'h100, 32'd4, 32'h0, 4'd5);
    wait_drain("load_word");
  endtask

  task automatic test_load_extend();
    exp_req_q.push_back('{we: 1'b0, size: SIZE_BYTE, addr: 32'h201, wdata: 32'h0});
    exp_req_q.push_back('{we: 1'b0, size: SIZE_BYTE, addr: 32'h203, wdata: 32'h0});
    exp_req_q.push_back('{we: 1'b0, size: SIZE_HALF, addr: 32'h206, wdata: 32'h0});
    exp_req_q.push_back('{we: 1'b0, size: SIZE_HALF, addr: 32'h20A, wdata: 32'h0});
    rdata_q.push_back(32'h80);
    rdata_q.push_back(32'h80);
    rdata_q.push_back(32'h8001);
    rdata_q.push_back(32'hABCD8001);
    exp_cdb_q.push_back('{tag: 4'd1, data: 32'hFFFFFF80});
    exp_cdb_q.push_back('{tag: 4'd2, data: 32'h00000080});
    exp_cdb_q.push_back('{tag: 4'd3, data: 32'hFFFF8001});
    exp_cdb_q.push_back('{tag: 4'd4, data: 32'h00008001});
    enq(OP_LB,  32'h200, 32'd1, 32'h0, 4'd1);
    enq(OP_LBU, 32'h200, 32'd3, 32'h0, 4'd2);
    enq(OP_LH,  32'h200, 32'd6, 32'h0, 4'd3);
    enq(OP_LHU, 32'h210, 32'hFFFFFFFA, 32'h0, 4'd4);
    wait_drain("load_extend");
  endtask

  task automatic test_store_commit();
    int base;
    exp_sr_q.push_back(4'd3);
    enq(OP_SW, 32'h300, 32'hFFFFFFF8, 32'hCAFEF00D, 4'd3);
    vectors++;
    if (store_ready_valid !== 1'b1 || store_ready_tag !== 4'd3) begin
      miscompares++;
      $display("FAIL store_ready_next_cycle: valid=%b tag=%0d, required valid=1 tag=3",
               store_ready_valid, store_ready_tag);
    end
    base = req_seen;
    commit(4'd9);
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (req_seen != base) begin
      miscompares++;
      $display("FAIL store_before_commit: %0d requests, required 0", req_seen - base);
    end
    exp_req_q.push_back('{we: 1'b1, size: SIZE_WORD, addr: 32'h2F8, wdata: 32'hCAFEF00D});
    commit(4'd3);
    wait_drain("store_commit");
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 14; i++) begin
      exp_sr_q.push_back(TAG_W'(i));
      enq(OP_SW, 32'h400 + 32'(4 * i), 32'h0, 32'h1000 + 32'(i), TAG_W'(i));
    end
    vectors++;
    if (is_full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_at_14: is_full=%b, required 0", is_full);
    end
    exp_sr_q.push_back(4'd14);
    enq(OP_SW, 32'h400 + 32'd56, 32'h0, 32'h100E, 4'd14);
    vectors++;
    if (is_full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_at_15: is_full=%b, required 1", is_full);
    end
    exp_req_q.push_back('{we: 1'b1, size: SIZE_WORD, addr: 32'h400, wdata: 32'h1000});
    commit(4'd0);
    wait_drain("full_pop");
    vectors++;
    if (is_full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_after_pop: is_full=%b, required 0", is_full);
    end
    exp_sr_q.push_back(4'd15);
    enq(OP_SW, 32'h400 + 32'd60, 32'h0, 32'h100F, 4'd15);
    vectors++;
    if (is_full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_refill: is_full=%b, required 1", is_full);
    end
    for (int i = 1; i < 16; i++) begin
      exp_req_q.push_back('{we: 1'b1, size: SIZE_WORD, addr: 32'h400 + 32'(4 * i), wdata: 32'h1000 + 32'(i)});
      commit(TAG_W'(i));
    end
    wait_drain("wrap_drain");
    vectors++;
    if (is_full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_after_drain: is_full=%b, required 0", is_full);
    end
  endtask

  task automatic test_clear();
    int base;
    mem_lat = 4;
    exp_sr_q.push_back(4'd1);
    enq(OP_SW, 32'h500, 32'h0, 32'h55AA55AA, 4'd1);
    enq(OP_LW, 32'h600, 32'h0, 32'h0, 4'd2);
    enq(OP_LB, 32'h604, 32'h0, 32'h0, 4'd3);
    exp_req_q.push_back('{we: 1'b1, size: SIZE_WORD, addr: 32'h500, wdata: 32'h55AA55AA});
    base = req_seen;
    commit(4'd1);
    wait_req(base, "clear_store");
    pulse_clear();
    wait_drain("clear_store");
    // Load in flight when the flush arrives: response arrives, no broadcast.
    exp_req_q.push_back('{we: 1'b0, size: SIZE_WORD, addr: 32'h700, wdata: 32'h0});
    rdata_q.push_back(32'h11111111);
    base = req_seen;
    enq(OP_LW, 32'h700, 32'h0, 32'h0, 4'd6);
    wait_req(base, "clear_load");
    pulse_clear();
    wait_drain("clear_load");
    mem_lat = 1;
    exp_req_q.push_back('{we: 1'b0, size: SIZE_WORD, addr: 32'h704, wdata: 32'h0});
    rdata_q.push_back(32'h12345678);
    exp_cdb_q.push_back('{tag: 4'd7, data: 32'h12345678});
    enq(OP_LW, 32'h700, 32'd4, 32'h0, 4'd7);
    wait_drain("after_clear");
  endtask

  task automatic test_io_load();
`ifdef LSB_IO_SAFE_EN
    int base;
    rdata_q.push_back(32'hA5A5A5A5);
    exp_cdb_q.push_back('{tag: 4'd8, data: 32'hA5A5A5A5});
    base = req_seen;
    enq(OP_LW, 32'h30000, 32'd4, 32'h0, 4'd8);
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (req_seen != base) begin
      miscompares++;
      $display("FAIL io_speculative: %0d requests before commit, required 0", req_seen - base);
    end
    exp_req_q.push_back('{we: 1'b0, size: SIZE_WORD, addr: 32'h30004, wdata: 32'h0});
    commit(4'd8);
    wait_drain("io_load");
`else
    exp_req_q.push_back('{we: 1'b0, size: SIZE_WORD, addr: 32'h30004, wdata: 32'h0});
    rdata_q.push_back(32'hA5A5A5A5);
    exp_cdb_q.push_back('{tag: 4'd8, data: 32'hA5A5A5A5});
    enq(OP_LW, 32'h30000, 32'd4, 32'h0, 4'd8);
    wait_drain("io_load");
`endif
  endtask

  initial begin : main
    test_reset();
    test_load_word();
    test_load_extend();
    test_store_commit();
    test_full_wrap();
    test_clear();
    test_io_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
